// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipe (load-use, SRAM wait, exceptions, MULT/DIV FSM)
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_register_d,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        mem_wait,
  input  logic        exc_flush,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        load_use, md_stall;
  assign load_use = ex_mem_read && (ex_register_d != 5'd0) &&
                    ((id_uses_rs && id_rs == ex_register_d) || (id_uses_rt && id_rt == ex_register_d));
  assign md_stall = (state_q == BUSY) || (state_q == IDLE && ex_md_start);
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = !rst && state_q == BUSY;
    md_done      = !rst && state_q == DONE;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end else if (exc_flush) begin
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end else if (mem_wait) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
    end else if (md_stall) begin
      {pc_en, if_id_en, id_ex_en} = 3'b000;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      {pc_en, if_id_en} = 2'b00;
      id_ex_flush = 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst || exc_flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        IDLE: if (ex_md_start) begin
          state_d = BUSY;
          cnt_d   = ex_md_is_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
        end
        BUSY: begin
          cnt_d   = cnt_q - 6'd1;
          state_d = (cnt_q == 6'd1) ? DONE : BUSY;
        end
        default: state_d = IDLE;
      endcase
    end
    stall_cycles_d = rst ? 32'd0 :
                     (!pc_en && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    state_q        <= state_d;
    cnt_q          <= cnt_d;
    stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
endmodule
